// File: rtl/alu_result_framer_pkg.sv
// alu_result_framer_pkg: frame type code, framer states
// and the default-width result buffer entry.
package alu_result_framer_pkg;

  localparam logic [7:0] FRAME_TYPE_RES = 8'hA1;
  localparam int RES_W = 8;
  localparam int SEQ_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  typedef struct packed {
    logic [SEQ_W-1:0] id;
    logic [RES_W-1:0] result;
  } fifo_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: synchronous FIFO, sync active-high reset.
// push/pop/din in; dout (head), full, empty, level out.
module alu_res_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so the
  // difference is the occupancy directly.
  assign level   = wr_q - rd_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_framer.sv
// alu_result_framer: buffers valid ALU results with a sequence
// ID and emits each as a header+data frame on a SOF/EOF stream.
// In : CLK, RST, EX_ALU, EX_ALU_VLD, TX_DST_RDY
// Out: TX_DATA, TX_SOF, TX_EOF, TX_SRC_RDY, OVERFLOW, FIFO_LEVEL
module alu_result_framer
  import alu_result_framer_pkg::*;
#(
  parameter int DATA_WIDTH = RES_W,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_WIDTH   = SEQ_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       EX_ALU,
  input  logic                        EX_ALU_VLD,
  output logic [OUT_WIDTH-1:0]        TX_DATA,
  output logic                        TX_SOF,
  output logic                        TX_EOF,
  output logic                        TX_SRC_RDY,
  input  logic                        TX_DST_RDY,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] result;
  } entry_t;

  localparam int EW = ID_WIDTH + DATA_WIDTH;

  state_t               state_q, state_d;
  entry_t               hold_q, hold_d, head;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 ovf_q;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 sof_q, sof_d;
  logic                 eof_q, eof_d;
  logic                 rdy_q, rdy_d;
  logic                 full, empty;
  logic                 push, pop, xfer;

  // Full is the pre-edge state, so a pop in the
  // same cycle never makes room for the push.
  assign push = EX_ALU_VLD & ~full;
  assign xfer = rdy_q & TX_DST_RDY;

  alu_res_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   ({id_q, EX_ALU}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (FIFO_LEVEL)
  );

  function automatic logic [OUT_WIDTH-1:0] hdr_word(entry_t e);
    hdr_word = '0;
    hdr_word[ID_WIDTH+7:0] = {e.id, FRAME_TYPE_RES};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] res_word(entry_t e);
    res_word = '0;
    res_word[DATA_WIDTH-1:0] = e.result;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      id_q    <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      rdy_q   <= rdy_d;
      if (push) id_q <= id_q + ID_WIDTH'(1);
      if (EX_ALU_VLD & full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) state_d = DATA;
      end
      DATA: begin
        if (xfer) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    hold_d = pop ? head : hold_q;
  end

  // Next values of the output registers. Entering HDR
  // from IDLE spends one cycle loading the header; the
  // back-to-back path loads it straight from the FIFO head.
  always_comb begin
    data_d = data_q;
    sof_d  = sof_q;
    eof_d  = eof_q;
    rdy_d  = rdy_q;
    unique case (state_q)
      IDLE: begin
        data_d = '0;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        rdy_d  = 1'b0;
      end
      HDR: begin
        if (!rdy_q) begin
          data_d = hdr_word(hold_q);
          sof_d  = 1'b1;
          eof_d  = 1'b0;
          rdy_d  = 1'b1;
        end else if (xfer) begin
          data_d = res_word(hold_q);
          sof_d  = 1'b0;
          eof_d  = 1'b1;
          rdy_d  = 1'b1;
        end
      end
      DATA: begin
        if (xfer) begin
          if (!empty) begin
            data_d = hdr_word(head);
            sof_d  = 1'b1;
            eof_d  = 1'b0;
            rdy_d  = 1'b1;
          end else begin
            data_d = '0;
            sof_d  = 1'b0;
            eof_d  = 1'b0;
            rdy_d  = 1'b0;
          end
        end
      end
      default: begin
        data_d = '0;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        rdy_d  = 1'b0;
      end
    endcase
  end

  assign TX_DATA    = data_q;
  assign TX_SOF     = sof_q;
  assign TX_EOF     = eof_q;
  assign TX_SRC_RDY = rdy_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_alu_result_framer.sv
// tb_alu_result_framer: directed and random stimulus with a
// word-queue scoreboard for the ALU result framer.
module tb_alu_result_framer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  EX_ALU = '0;
  logic        EX_ALU_VLD = 1'b0;
  logic        TX_DST_RDY = 1'b0;
  logic [15:0] TX_DATA;
  logic        TX_SOF;
  logic        TX_EOF;
  logic        TX_SRC_RDY;
  logic        OVERFLOW;
  logic [3:0]  FIFO_LEVEL;

  alu_result_framer dut (
    .CLK        (CLK),
    .RST        (RST),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD),
    .TX_DATA    (TX_DATA),
    .TX_SOF     (TX_SOF),
    .TX_EOF     (TX_EOF),
    .TX_SRC_RDY (TX_SRC_RDY),
    .TX_DST_RDY (TX_DST_RDY),
    .OVERFLOW   (OVERFLOW),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } word_t;

  word_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mid = '0;
  int         accepted = 0;
  int         frames_done = 0;
  bit         mon_en = 1'b0;
  bit         rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the head of
  // the expected stream; stalled words must not change.
  logic [15:0] p_data;
  logic        p_sof, p_eof;
  bit          p_stall = 1'b0;
  word_t       w;

  always @(negedge CLK) begin
    if (!mon_en) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        check("stable_data", 32'(TX_DATA), 32'(p_data));
        check("stable_ctl", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}),
              32'({p_sof, p_eof, 1'b1}));
      end
      if (TX_SRC_RDY && TX_DST_RDY) begin
        check("word_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("word_data", 32'(TX_DATA), 32'(w.data));
          check("word_sof_eof", 32'({TX_SOF, TX_EOF}),
                32'({w.sof, w.eof}));
          if (TX_EOF) frames_done++;
        end
      end
      p_stall = TX_SRC_RDY && !TX_DST_RDY;
      p_data  = TX_DATA;
      p_sof   = TX_SOF;
      p_eof   = TX_EOF;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (rand_rdy) TX_DST_RDY = 1'($urandom_range(0, 1));
  endtask

  // One cycle of VLD; an accepted result adds its two
  // frame words to the expected stream.
  task automatic send(input logic [7:0] r, input bit acc);
    EX_ALU     = r;
    EX_ALU_VLD = 1'b1;
    if (acc) begin
      exp_q.push_back('{{mid, 8'hA1}, 1'b1, 1'b0});
      exp_q.push_back('{16'(r), 1'b0, 1'b1});
      mid++;
      accepted++;
    end
    step();
    EX_ALU_VLD = 1'b0;
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    rand_rdy   = 1'b0;
    EX_ALU_VLD = 1'b0;
    RST        = 1'b1;
    step();
    step();
    RST = 1'b0;
    exp_q.delete();
    mid         = '0;
    accepted    = 0;
    frames_done = 0;
    mon_en      = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || TX_SRC_RDY) && n < 3000) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values
    TX_DST_RDY = 1'b1;
    RST = 1'b1;
    step();
    step();
    @(negedge CLK);
    check("rst_data", 32'(TX_DATA), 32'd0);
    check("rst_ctl", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}), 32'd0);
    check("rst_level", 32'(FIFO_LEVEL), 32'd0);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    do_reset();

    // Single result and latency
    TX_DST_RDY = 1'b1;
    send(8'h3C, 1'b1);
    @(negedge CLK);
    check("t1_level_k", 32'(FIFO_LEVEL), 32'd1);
    check("t1_rdy_k", 32'(TX_SRC_RDY), 32'd0);
    step();
    @(negedge CLK);
    check("t1_rdy_k1", 32'(TX_SRC_RDY), 32'd0);
    step();
    @(negedge CLK);
    check("t1_hdr_k2", 32'(TX_DATA), 32'h00A1);
    check("t1_ctl_k2", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}), 32'b101);
    step();
    @(negedge CLK);
    check("t1_data_k3", 32'(TX_DATA), 32'h003C);
    check("t1_ctl_k3", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}), 32'b011);
    step();
    @(negedge CLK);
    check("t1_idle_k4", 32'(TX_SRC_RDY), 32'd0);
    check("t1_frames", 32'(frames_done), 32'd1);

    // Backpressure with random DST_RDY
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
    drain("t2");
    rand_rdy = 1'b0;
    check("t2_frames", 32'(frames_done), 32'd3);

    // Overflow: 8 in FIFO, 1 held, 3 dropped
    do_reset();
    TX_DST_RDY = 1'b0;
    for (int i = 0; i < 12; i++) send(8'($urandom), i < 9);
    @(negedge CLK);
    check("t3_level", 32'(FIFO_LEVEL), 32'd8);
    check("t3_ovf", 32'(OVERFLOW), 32'd1);
    check("t3_hdr", 32'(TX_DATA), 32'h00A1);
    TX_DST_RDY = 1'b1;
    drain("t3");
    check("t3_frames", 32'(frames_done), 32'd9);
    check("t3_ovf_sticky", 32'(OVERFLOW), 32'd1);
    check("t3_level_end", 32'(FIFO_LEVEL), 32'd0);

    // Full FIFO, push races a pop
    do_reset();
    TX_DST_RDY = 1'b0;
    for (int i = 0; i < 9; i++) send(8'(i + 16), 1'b1);
    step();
    step();
    @(negedge CLK);
    check("t5_level_full", 32'(FIFO_LEVEL), 32'd8);
    check("t5_ovf_clear", 32'(OVERFLOW), 32'd0);
    TX_DST_RDY = 1'b1;
    step();
    send(8'h77, 1'b0);
    TX_DST_RDY = 1'b0;
    @(negedge CLK);
    check("t5_level", 32'(FIFO_LEVEL), 32'd7);
    check("t5_ovf", 32'(OVERFLOW), 32'd1);
    check("t5_next_hdr", 32'(TX_DATA), 32'h01A1);
    TX_DST_RDY = 1'b1;
    drain("t5");
    check("t5_frames", 32'(frames_done), 32'd9);

    // ID wrap over 257 frames
    do_reset();
    TX_DST_RDY = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(8'($urandom), 1'b1);
      step();
    end
    drain("t4");
    check("t4_frames", 32'(frames_done), 32'd257);
    check("t4_ovf", 32'(OVERFLOW), 32'd0);

    // Reset during the data word
    do_reset();
    TX_DST_RDY = 1'b0;
    send(8'h5A, 1'b1);
    step();
    step();
    TX_DST_RDY = 1'b1;
    step();
    TX_DST_RDY = 1'b0;
    @(negedge CLK);
    check("t6_in_data", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}), 32'b011);
    mon_en = 1'b0;
    RST = 1'b1;
    step();
    @(negedge CLK);
    check("t6_rst_data", 32'(TX_DATA), 32'd0);
    check("t6_rst_ctl", 32'({TX_SOF, TX_EOF, TX_SRC_RDY}), 32'd0);
    check("t6_rst_level", 32'(FIFO_LEVEL), 32'd0);
    do_reset();
    TX_DST_RDY = 1'b1;
    send(8'hC3, 1'b1);
    drain("t6");
    check("t6_frames", 32'(frames_done), 32'd1);

    // Random traffic, kept below buffer capacity
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && (accepted - frames_done) < 6)
        send(8'($urandom), 1'b1);
      else
        step();
    end
    drain("rnd");
    rand_rdy = 1'b0;
    check("rnd_frames", 32'(frames_done), 32'(accepted));
    check("rnd_ovf", 32'(OVERFLOW), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
